multi_cycle_ctrl: RTL and testbench

//  Main control FSM for the multi-cycle MIPS datapath. It is the producer side of the

---
 rtl/multi_cycle_ctrl_pkg.sv | 122 ++++++++++++
 rtl/multi_cycle_ctrl_if.sv | 43 ++++
 rtl/multi_cycle_ctrl.sv | 91 +++++++++
 tb/tb_multi_cycle_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_ctrl_pkg.sv
`default_nettype none
// ==========================================================================
// multi_cycle_ctrl_pkg : opcodes, ALU-op codes, FSM states, Moore decode
// Rev 1.0
// ==========================================================================
package multi_cycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Shared with the ALU-control decoder; 2'b01 is reserved and never driven.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_SUB   = 2'b11;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RTWB   = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_e;

  // Pure state-decoded outputs; the mem_ready-gated terms are added in the top.
  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic [1:0] aluop;
    logic       done;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
  endfunction

  function automatic ctrl_t moore_decode(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.memread = 1'b1;
        c.alusrcb = 2'b01;
        c.aluop   = ALUOP_ADD;
      end
      S_DECODE: begin
        c.alusrcb = 2'b11;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
        c.done     = 1'b1;
      end
      S_MEMWR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      S_EXEC: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b00;
        c.aluop   = ALUOP_RTYPE;
      end
      S_RTWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
        c.done     = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca     = 1'b1;
        c.alusrcb     = 2'b00;
        c.aluop       = ALUOP_SUB;
        c.pcwritecond = 1'b1;
        c.pcsource    = 2'b01;
        c.done        = 1'b1;
      end
      S_JUMP: begin
        c.pcwrite  = 1'b1;
        c.pcsource = 2'b10;
        c.done     = 1'b1;
      end
      S_ADDIWB: begin
        c.regwrite = 1'b1;
        c.done     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_cycle_ctrl_if.sv
`default_nettype none
// ==========================================================================
// multi_cycle_ctrl_if : controller <-> datapath control/handshake bundle
// Rev 1.0
// ==========================================================================
interface multi_cycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pcwrite;
  logic             pcwritecond;
  logic             iord;
  logic             memread;
  logic             memwrite;
  logic             irwrite;
  logic             memtoreg;
  logic             regdst;
  logic             regwrite;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       pcsource;
  logic [1:0]       aluop;
  logic             illegal;
  logic             instr_done;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, zero, mem_ready,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
           regdst, regwrite, alusrca, alusrcb, pcsource, aluop, illegal,
           instr_done, instr_count
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
           regdst, regwrite, alusrca, alusrcb, pcsource, aluop, illegal,
           instr_done, instr_count
  );
endinterface
`default_nettype wire

// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
// ==========================================================================
// multi_cycle_ctrl : main control FSM of the multi-cycle MIPS datapath
// Rev 1.0
// ==========================================================================
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  wire logic           clk,
  input  wire logic           rst,
  multi_cycle_ctrl_if.master  ctrl_if
);

  state_e           state_q, state_d;
  ctrl_t            ctl_q;
  logic [CNT_W-1:0] count_q;
  logic             in_fetch;
  logic             done;
  logic             unused_zero;

  // The zero flag is consumed by the PC logic together with pcwritecond.
  assign unused_zero = ctrl_if.zero;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  state_d = ctrl_if.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (ctrl_if.opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (ctrl_if.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = ctrl_if.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = ctrl_if.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_RTWB;
      S_RTWB:   state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  assign in_fetch = (state_q == S_FETCH);
  assign done     = ctl_q.done | ((state_q == S_MEMWR) & ctrl_if.mem_ready);

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RST;
      ctl_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= moore_decode(state_d);
      if (done) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign ctrl_if.pcwrite     = ctl_q.pcwrite | (in_fetch & ctrl_if.mem_ready);
  assign ctrl_if.irwrite     = in_fetch & ctrl_if.mem_ready;
  assign ctrl_if.pcwritecond = ctl_q.pcwritecond;
  assign ctrl_if.iord        = ctl_q.iord;
  assign ctrl_if.memread     = ctl_q.memread;
  assign ctrl_if.memwrite    = ctl_q.memwrite;
  assign ctrl_if.memtoreg    = ctl_q.memtoreg;
  assign ctrl_if.regdst      = ctl_q.regdst;
  assign ctrl_if.regwrite    = ctl_q.regwrite;
  assign ctrl_if.alusrca     = ctl_q.alusrca;
  assign ctrl_if.alusrcb     = ctl_q.alusrcb;
  assign ctrl_if.pcsource    = ctl_q.pcsource;
  assign ctrl_if.aluop       = ctl_q.aluop;
  assign ctrl_if.illegal     = (state_q == S_DECODE) & ~op_supported(ctrl_if.opcode);
  assign ctrl_if.instr_done  = done;
  assign ctrl_if.instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_multi_cycle_ctrl : random + directed instruction stream vs phase model
// Rev 1.0
// ==========================================================================
module tb_multi_cycle_ctrl;

  localparam int CNT_W = 4;
  localparam logic [5:0] T_RT   = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_ADDI = 6'b001000;

  typedef struct packed {
    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       memtoreg, regdst, regwrite, alusrca;
    logic [1:0] alusrcb, pcsource, aluop;
    logic       illegal, instr_done;
  } outs_t;

  logic  clk;
  logic  rst;
  int    n_chk;
  int    n_pass;
  int    retired;
  outs_t act;

  multi_cycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

  multi_cycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign act = {bus.pcwrite, bus.pcwritecond, bus.iord, bus.memread, bus.memwrite,
                bus.irwrite, bus.memtoreg, bus.regdst, bus.regwrite, bus.alusrca,
                bus.alusrcb, bus.pcsource, bus.aluop, bus.illegal, bus.instr_done};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock of the model: inputs are already driven; sample mid-cycle.
  task automatic cycle(input string tag, input outs_t e);
    @(negedge clk);
    check_eq(tag, 32'(act), 32'(e));
    check_eq({tag, "_cnt"}, 32'(bus.instr_count), 32'(retired % (1 << CNT_W)));
    @(posedge clk);
    #1;
    if (e.instr_done) retired++;
  endtask

  task automatic rnd_ready();
    bus.mem_ready = 1'($urandom);
  endtask

  // kind 0: instruction fetch, 1: data read, 2: data write
  task automatic mem_phase(input string tag, input outs_t base, input int waits, input int kind);
    int    w;
    outs_t e;
    w = (waits < 0) ? int'($urandom_range(0, 3)) : waits;
    for (int i = 0; i <= w; i++) begin
      e = base;
      bus.mem_ready = (i == w);
      if (kind == 0) begin
        e.pcwrite = bus.mem_ready;
        e.irwrite = bus.mem_ready;
      end
      if (kind == 2) e.instr_done = bus.mem_ready;
      cycle(tag, e);
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    outs_t e;
    logic  legal;
    bus.opcode = op;
    bus.zero   = 1'($urandom);
    e = '0; e.memread = 1'b1; e.alusrcb = 2'b01;
    mem_phase("fetch", e, fw, 0);
    legal = op inside {T_RT, T_LW, T_SW, T_BEQ, T_J, T_ADDI};
    rnd_ready();
    e = '0; e.alusrcb = 2'b11; e.illegal = ~legal;
    cycle("decode", e);
    case (op)
      T_LW, T_SW: begin
        rnd_ready();
        e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
        cycle("memadr", e);
        if (op == T_LW) begin
          e = '0; e.memread = 1'b1; e.iord = 1'b1;
          mem_phase("memrd", e, mw, 1);
          rnd_ready();
          e = '0; e.memtoreg = 1'b1; e.regwrite = 1'b1; e.instr_done = 1'b1;
          cycle("memwb", e);
        end else begin
          e = '0; e.memwrite = 1'b1; e.iord = 1'b1;
          mem_phase("memwr", e, mw, 2);
        end
      end
      T_RT: begin
        rnd_ready();
        e = '0; e.alusrca = 1'b1; e.aluop = 2'b10;
        cycle("exec", e);
        rnd_ready();
        e = '0; e.regdst = 1'b1; e.regwrite = 1'b1; e.instr_done = 1'b1;
        cycle("rtwb", e);
      end
      T_BEQ: begin
        rnd_ready();
        e = '0; e.alusrca = 1'b1; e.aluop = 2'b11; e.pcwritecond = 1'b1;
        e.pcsource = 2'b01; e.instr_done = 1'b1;
        cycle("branch", e);
      end
      T_J: begin
        rnd_ready();
        e = '0; e.pcwrite = 1'b1; e.pcsource = 2'b10; e.instr_done = 1'b1;
        cycle("jump", e);
      end
      T_ADDI: begin
        rnd_ready();
        e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
        cycle("addiex", e);
        rnd_ready();
        e = '0; e.regwrite = 1'b1; e.instr_done = 1'b1;
        cycle("addiwb", e);
      end
      default: ;
    endcase
  endtask

  initial begin
    outs_t       e;
    logic [5:0]  ops [6];
    logic [5:0]  op;
    int          sel;
    ops[0] = T_RT; ops[1] = T_LW; ops[2] = T_SW;
    ops[3] = T_BEQ; ops[4] = T_J; ops[5] = T_ADDI;
    n_chk = 0; n_pass = 0; retired = 0;
    rst = 1'b1;
    bus.opcode = '0; bus.zero = 1'b0; bus.mem_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outs", 32'(act), 32'h0);
    check_eq("reset_cnt", 32'(bus.instr_count), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle("rst_state", '0);

    // Directed scenarios
    run_instr(T_LW, 0, 0);
    run_instr(T_RT, 0, 0);
    run_instr(T_BEQ, 0, 0);
    run_instr(T_SW, 0, 3);
    run_instr(6'b111111, 0, 0);
    run_instr(T_J, 1, 0);
    run_instr(T_ADDI, 2, 0);

    // Reset while stalled in the data-read state
    bus.opcode = T_LW;
    bus.mem_ready = 1'b1;
    e = '0; e.memread = 1'b1; e.alusrcb = 2'b01; e.pcwrite = 1'b1; e.irwrite = 1'b1;
    cycle("rf_fetch", e);
    e = '0; e.alusrcb = 2'b11;
    cycle("rf_decode", e);
    e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
    cycle("rf_memadr", e);
    bus.mem_ready = 1'b0;
    e = '0; e.memread = 1'b1; e.iord = 1'b1;
    cycle("rf_memrd", e);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_async_outs", 32'(act), 32'h0);
    check_eq("rst_async_cnt", 32'(bus.instr_count), 32'h0);
    retired = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle("post_rst", '0);

    // Random stream; enough retires to wrap the 4-bit counter more than once
    for (int n = 0; n < 48; n++) begin
      sel = int'($urandom_range(0, 7));
      op  = (sel < 6) ? ops[sel] : 6'($urandom);
      run_instr(op, -1, -1);
      if (retired == 16) check_eq("wrap", 32'(bus.instr_count), 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
